mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage data-memory controller. It consumes the memory-access fields held by the EX/MEM pipeline register and runs the access on a req/ack data-memory bus.
- While an access is outstanding it raises stall_ctrl_o, which freezes the EX/MEM register and the earlier stages.
- It presents writeback fields, with load data substituted in, to the MEM/WB register.
- It flags misaligned addresses and bus timeouts.

Parameters:
- TIMEOUT, 16, max BUSY cycles to wait for dmem_ack_i before aborting (range 2..255).
- CNT_W, 8, width of the timeout counter.

Ports:
- clk_i  in  1  clock, posedge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- reg_write_addr_i  in  5  dest register from EX/MEM.
- reg_write_data_i  in  32  ALU result from EX/MEM.
- reg_write_ctrl_i  in  1  writeback enable from EX/MEM.
- mem_addr_i  in  32  data address.
- mem_read_ctrl_i  in  1  load request.
- mem_write_ctrl_i  in  1  store request.
- mem_write_data_i  in  32  store data.
- reg_write_addr_o  out  5  dest register to MEM/WB.
- reg_write_data_o  out  32  writeback data to MEM/WB.
- reg_write_ctrl_o  out  1  writeback enable to MEM/WB.
- stall_ctrl_o  out  1  freeze upstream pipeline registers.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  1 = write.
- dmem_addr_o  out  32  word address; bits [1:0] are always 0.
- dmem_wdata_o  out  32  write data.
- dmem_ack_i  in  1  bus completion.
- dmem_rdata_i  in  32  read data; valid only with ack.
- misalign_o  out  1  1-cycle pulse: access dropped because addr[1:0] != 0.
- timeout_o  out  1  1-cycle pulse: access aborted because no ack arrived.

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - state = IDLE, counter = 0, captured data = 0.
  - dmem_req_o, dmem_we_o, misalign_o, timeout_o = 0.
  - dmem_addr_o, dmem_wdata_o = 0.
  - A reset mid-access drops dmem_req_o immediately; the bus must tolerate an abandoned request.
- Access decode:
  - acc = mem_read_ctrl_i | mem_write_ctrl_i.
  - If read and write are both set, write wins and no load data is substituted.
- States are IDLE, BUSY, DONE.
- IDLE:
  - stall_ctrl_o = acc & aligned.
  - If acc & aligned: register addr, we and wdata, set dmem_req_o = 1, clear counter, go to BUSY.
  - If acc & misaligned: no bus activity; pulse misalign_o next cycle; stay in IDLE.
  - In the misaligned case, reg_write_ctrl_o = 0 this cycle, giving a bubble in WB, and stall_ctrl_o = 0.
  - Otherwise pass through: reg_write_*_o = reg_write_*_i.
- BUSY:
  - stall_ctrl_o = 1 and reg_write_ctrl_o = 0.
  - dmem_req_o, addr, we and wdata are held stable until ack is sampled.
  - dmem_ack_i = 1: capture dmem_rdata_i if it is a read, drop req, go to DONE.
  - Else if counter == TIMEOUT-1: drop req, pulse timeout_o, go to DONE with an error flag set.
  - Else increment counter.
  - ack and timeout in the same cycle: ack wins.
  - ack may arrive in the first BUSY cycle.
- DONE:
  - stall_ctrl_o = 0, so EX/MEM advances at the end of this cycle.
  - reg_write_addr_o = reg_write_addr_i.
  - reg_write_data_o = captured rdata for a load, else reg_write_data_i.
  - reg_write_ctrl_o = reg_write_ctrl_i & ~err.
  - Unconditionally go to IDLE. DONE never re-issues, because its inputs still belong to the completed instruction.
- Latency:
  - A memory instruction occupies MEM for 1 (IDLE) + N (BUSY, N ≥ 1) + 1 (DONE) cycles, with stall high for N+1 cycles.
  - Minimum is 3 cycles when ack comes in the first BUSY cycle.
  - Back-to-back memory instructions each pay the full latency.
  - A non-memory instruction passes through in 1 cycle, combinationally.
- dmem_ack_i while IDLE or DONE: ignored.
- No pipelining of bus transactions: at most one request is outstanding.

Decomposition:
- Shared package (cpu_pkg):
  - state enum: IDLE, BUSY, DONE.
  - DATA_W = 32, REG_ADDR_W = 5.
  - WORD_ALIGN_MASK = 2'b11.
- One natural sub-module, mem_timeout_counter: a counter with clear/enable and a terminal-count output at TIMEOUT-1.
- The FSM, the capture registers and the output muxing remain in mem_access_unit.

Test Plan:
- ALU op, no access (reg_write_ctrl_i=1, addr=5, data=0x1234) → same-cycle pass-through, stall_ctrl_o=0, dmem_req_o never asserted.
- Load from 0x100 with ack in the first BUSY cycle, rdata=0xDEADBEEF:
  - stall is high for 2 cycles.
  - In DONE, reg_write_data_o=0xDEADBEEF and reg_write_ctrl_o=1.
  - dmem_req_o is high for exactly 1 cycle with we=0 and addr=0x100.
- Store 0xCAFEF00D to 0x200 with ack after 5 cycles:
  - req, we, addr and wdata stay stable for all 5 BUSY cycles.
  - stall is high for 6 cycles.
  - DONE passes reg_write_data_i through.
- Load to 0x103:
  - misalign_o pulses once.
  - No dmem_req_o, stall_ctrl_o stays 0, reg_write_ctrl_o=0.
- Load with no ack, TIMEOUT=4:
  - req drops after 4 BUSY cycles.
  - timeout_o pulses, and reg_write_ctrl_o=0 in DONE.
  - A late ack arriving in IDLE is ignored.
- Back-to-back loads, then rst_n_i pulsed low mid-BUSY:
  - The second load starts only after DONE.
  - On reset, dmem_req_o and stall_ctrl_o fall asynchronously and state returns to IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, MEM-stage FSM states and
// a word-alignment helper used by the data-memory access logic.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Bus-wait counter for the MEM stage.
// Ports: clk, rst_n, clr (restart at 0), en (count), tc (count == TIMEOUT-1).
module mem_timeout_counter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory controller: runs one req/ack access per memory
// instruction, stalls upstream while busy, substitutes load data into the
// writeback fields and flags misaligned addresses and bus timeouts.
// Ports: EX/MEM fields in (reg_write_*_i, mem_*_i), MEM/WB fields out
// (reg_write_*_o), stall_ctrl_o, dmem_* bus, misalign_o / timeout_o pulses.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [REG_ADDR_W-1:0] reg_write_addr_i,
    input  logic [DATA_W-1:0]     reg_write_data_i,
    input  logic                  reg_write_ctrl_i,
    input  logic [DATA_W-1:0]     mem_addr_i,
    input  logic                  mem_read_ctrl_i,
    input  logic                  mem_write_ctrl_i,
    input  logic [DATA_W-1:0]     mem_write_data_i,
    output logic [REG_ADDR_W-1:0] reg_write_addr_o,
    output logic [DATA_W-1:0]     reg_write_data_o,
    output logic                  reg_write_ctrl_o,
    output logic                  stall_ctrl_o,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_W-1:0]     dmem_addr_o,
    output logic [DATA_W-1:0]     dmem_wdata_o,
    input  logic                  dmem_ack_i,
    input  logic [DATA_W-1:0]     dmem_rdata_i,
    output logic                  misalign_o,
    output logic                  timeout_o
);

    state_e            state;
    logic              acc;
    logic              aligned;
    logic              issue;
    logic              tc;
    logic              load_q;
    logic              err;
    logic [DATA_W-1:0] rdata_q;
    logic              stall;

    assign acc     = mem_read_ctrl_i | mem_write_ctrl_i;
    assign aligned = is_aligned(mem_addr_i[1:0]);
    assign issue   = (state == IDLE) & acc & aligned;

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_cnt (
        .clk   (clk_i),
        .rst_n (rst_n_i),
        .clr   (issue),
        .en    (state == BUSY),
        .tc    (tc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            rdata_q      <= '0;
            load_q       <= 1'b0;
            err          <= 1'b0;
            misalign_o   <= 1'b0;
            timeout_o    <= 1'b0;
        end else begin
            misalign_o <= 1'b0;
            timeout_o  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (issue) begin
                        state        <= BUSY;
                        dmem_req_o   <= 1'b1;
                        dmem_we_o    <= mem_write_ctrl_i;
                        dmem_addr_o  <= {mem_addr_i[DATA_W-1:2], 2'b00};
                        dmem_wdata_o <= mem_write_data_i;
                        // a store wins over a simultaneous load
                        load_q       <= ~mem_write_ctrl_i;
                        err          <= 1'b0;
                    end else if (acc) begin
                        misalign_o <= 1'b1;
                    end
                end
                BUSY: begin
                    if (dmem_ack_i) begin
                        if (load_q) begin
                            rdata_q <= dmem_rdata_i;
                        end
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        state      <= DONE;
                    end else if (tc) begin
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        timeout_o  <= 1'b1;
                        err        <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    // inputs still hold the finished instruction: never re-issue
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        reg_write_addr_o = reg_write_addr_i;
        reg_write_data_o = reg_write_data_i;
        reg_write_ctrl_o = reg_write_ctrl_i;
        stall            = 1'b0;
        unique case (state)
            IDLE: begin
                stall = acc & aligned;
                // the write happens in DONE (or is dropped when misaligned)
                if (acc) begin
                    reg_write_ctrl_o = 1'b0;
                end
            end
            BUSY: begin
                stall            = 1'b1;
                reg_write_ctrl_o = 1'b0;
            end
            DONE: begin
                if (load_q) begin
                    reg_write_data_o = rdata_q;
                end
                reg_write_ctrl_o = reg_write_ctrl_i & ~err;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // a pending issue in IDLE must not hold the pipeline during reset
    assign stall_ctrl_o = stall & rst_n_i;

endmodule
